// File: rtl/regfile_pkg.sv
// Shared parameters and types for the register-file read controller.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // X31 reads as zero, ignores writes and is never pending.
    localparam reg_addr_t XZR = 5'd31;

endpackage

// File: rtl/regfile_rd_ctrl_if.sv
// Writeback, claim and operand-read bus between decode/writeback and the register file.
interface regfile_rd_ctrl_if;

    logic                  wr_en;
    regfile_pkg::reg_addr_t wr_addr;
    regfile_pkg::reg_data_t wr_data;
    logic                  claim_en;
    regfile_pkg::reg_addr_t claim_addr;
    logic                  rd_req;
    regfile_pkg::reg_addr_t rd_addr_a;
    regfile_pkg::reg_addr_t rd_addr_b;
    logic                  rd_ready;
    logic                  rd_valid;
    regfile_pkg::reg_data_t rd_data_a;
    regfile_pkg::reg_data_t rd_data_b;

    modport master (
        output wr_en, wr_addr, wr_data, claim_en, claim_addr,
        output rd_req, rd_addr_a, rd_addr_b,
        input  rd_ready, rd_valid, rd_data_a, rd_data_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_req, rd_addr_a, rd_addr_b,
        output rd_ready, rd_valid, rd_data_a, rd_data_b
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with claim/clear logic and effective-pending lookup.
// Same-cycle write release of a pending read is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  logic      claim_en,
    input  reg_addr_t claim_addr,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    output logic      pend_a,
    output logic      pend_b
);

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_next_s;

    // Next pending vector: a claim beats a same-address clearing write.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < NREG; i++) begin
            if (claim_en && (claim_addr == reg_addr_t'(i)) && (reg_addr_t'(i) != XZR)) begin
                pending_next_s[i] = 1'b1;
            end else if (wr_en && (wr_addr == reg_addr_t'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Pending bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic logic write_releases(input reg_addr_t addr, input logic we,
                                            input reg_addr_t wa, input logic ce,
                                            input reg_addr_t ca);
        return we && (wa == addr) && (addr != XZR) && !(ce && (ca == addr));
    endfunction

    assign pend_a = pending_r[rd_addr_a] && !write_releases(rd_addr_a, wr_en, wr_addr, claim_en, claim_addr);
    assign pend_b = pending_r[rd_addr_b] && !write_releases(rd_addr_b, wr_en, wr_addr, claim_en, claim_addr);
`else
    assign pend_a = pending_r[rd_addr_a];
    assign pend_b = pending_r[rd_addr_b];
`endif

endmodule

// File: rtl/regfile_rd_ctrl.sv
// 32 x 64-bit register file with pending-stall operand reads and registered read data.
// Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module regfile_rd_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    regfile_rd_ctrl_if.slave  bus
);

    reg_data_t regs_r [NREG];
    reg_data_t data_a_s;
    reg_data_t data_b_s;
    reg_data_t rd_data_a_r;
    reg_data_t rd_data_b_r;
    logic      rd_valid_r;
    logic      pend_a_s;
    logic      pend_b_s;
    logic      rd_ready_s;
    logic      accept_s;

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .claim_en   (bus.claim_en),
        .claim_addr (bus.claim_addr),
        .rd_addr_a  (bus.rd_addr_a),
        .rd_addr_b  (bus.rd_addr_b),
        .pend_a     (pend_a_s),
        .pend_b     (pend_b_s)
    );

`ifdef REGFILE_BYPASS_EN
    function automatic reg_data_t read_mux(input reg_addr_t addr, input reg_data_t stored,
                                           input logic we, input reg_addr_t wa,
                                           input reg_data_t wd);
        reg_data_t v;
        if (addr == XZR) begin
            v = {DATA_W{1'b0}};
        end else if (we && (wa == addr)) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction
`else
    function automatic reg_data_t read_mux(input reg_addr_t addr, input reg_data_t stored);
        reg_data_t v;
        if (addr == XZR) begin
            v = {DATA_W{1'b0}};
        end else begin
            v = stored;
        end
        return v;
    endfunction
`endif

    // Storage update; X31 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (bus.wr_en && (bus.wr_addr == reg_addr_t'(i)) && (reg_addr_t'(i) != XZR)) begin
                    regs_r[i] <= bus.wr_data;
                end
            end
        end
    end

    // Operand read muxes.
    always_comb begin
        data_a_s = {DATA_W{1'b0}};
        data_b_s = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        data_a_s = read_mux(bus.rd_addr_a, regs_r[bus.rd_addr_a], bus.wr_en, bus.wr_addr, bus.wr_data);
        data_b_s = read_mux(bus.rd_addr_b, regs_r[bus.rd_addr_b], bus.wr_en, bus.wr_addr, bus.wr_data);
`else
        data_a_s = read_mux(bus.rd_addr_a, regs_r[bus.rd_addr_a]);
        data_b_s = read_mux(bus.rd_addr_b, regs_r[bus.rd_addr_b]);
`endif
    end

    assign rd_ready_s = !reset && !pend_a_s && !pend_b_s;
    assign accept_s   = bus.rd_req && rd_ready_s;

    // Output registers: valid pulses one cycle after accept, data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r  <= 1'b0;
            rd_data_a_r <= {DATA_W{1'b0}};
            rd_data_b_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            rd_valid_r  <= 1'b1;
            rd_data_a_r <= data_a_s;
            rd_data_b_r <= data_b_s;
        end else begin
            rd_valid_r  <= 1'b0;
        end
    end

    assign bus.rd_ready  = rd_ready_s;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data_a = rd_data_a_r;
    assign bus.rd_data_b = rd_data_b_r;

endmodule

// File: tb/tb_regfile_rd_ctrl.sv
// Scoreboard bench for regfile_rd_ctrl: directed test-plan cases then randomized traffic.
module tb_regfile_rd_ctrl;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_rd_ctrl_if bus ();

    regfile_rd_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int        due;
        reg_data_t a;
        reg_data_t b;
    } exp_t;

    exp_t      q[$];
    reg_data_t mem [NREG];
    bit        pend [NREG];
    reg_data_t last_a = 64'h0;
    reg_data_t last_b = 64'h0;
    int        checks = 0;
    int        passed = 0;
    int        cycle = 0;
    bit        mon_en = 1'b0;

    // Reference: pending as seen by a read this cycle, from the architectural rules.
    function automatic bit model_pend(input int x);
        if (x == 31) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (pend[x] && bus.wr_en && (int'(bus.wr_addr) == x) &&
            !(bus.claim_en && (int'(bus.claim_addr) == x))) return 1'b0;
`endif
        return pend[x];
    endfunction

    function automatic reg_data_t model_read(input int x);
        if (x == 31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wr_en && (int'(bus.wr_addr) == x)) return bus.wr_data;
`endif
        return mem[x];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic cyc(input bit rst, input bit we, input int wa, input reg_data_t wd,
                       input bit ce, input int ca, input bit rq, input int a, input int b);
        bit exp_ready;
        @(negedge clk);
        reset          = rst;
        bus.wr_en      = we;
        bus.wr_addr    = reg_addr_t'(wa);
        bus.wr_data    = wd;
        bus.claim_en   = ce;
        bus.claim_addr = reg_addr_t'(ca);
        bus.rd_req     = rq;
        bus.rd_addr_a  = reg_addr_t'(a);
        bus.rd_addr_b  = reg_addr_t'(b);
        #2;
        exp_ready = !rst && !model_pend(a) && !model_pend(b);
        if (mon_en) check("rd_ready", 64'(bus.rd_ready), 64'(exp_ready));
        if (rq && exp_ready) q.push_back('{cycle + 1, model_read(a), model_read(b)});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i]  = 64'h0;
                pend[i] = 1'b0;
            end
            q.delete();
            last_a = 64'h0;
            last_b = 64'h0;
        end else begin
            if (we && wa != 31) mem[wa] = wd;
            if (we) pend[wa] = 1'b0;
            if (ce && ca != 31) pend[ca] = 1'b1;
        end
        cycle++;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        return (r == 9) ? 31 : r;
    endfunction

    // Monitor: every valid pulse must match the oldest expected read, on schedule.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                if (q.size() == 0 || q[0].due != cycle) begin
                    checks++;
                    $display("FAIL unexpected_valid: got rd_valid=1 required 0 (cycle %0d)", cycle);
                end else begin
                    check("rd_data_a", bus.rd_data_a, q[0].a);
                    check("rd_data_b", bus.rd_data_b, q[0].b);
                    last_a = q[0].a;
                    last_b = q[0].b;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].due == cycle) begin
                checks++;
                $display("FAIL missing_valid: got rd_valid=%b required 1 (cycle %0d)", bus.rd_valid, cycle);
                void'(q.pop_front());
            end else begin
                check("hold_a", bus.rd_data_a, last_a);
                check("hold_b", bus.rd_data_b, last_b);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 64'h0;
        bus.claim_en = 1'b0; bus.claim_addr = 5'd0;
        bus.rd_req = 1'b0; bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd0;
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0);
        #1;
        check("reset_valid", 64'(bus.rd_valid), 64'h0);
        check("reset_data_a", bus.rd_data_a, 64'h0);

        // Read after reset, then write-then-read and XZR behaviour.
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 3, 31);
        cyc(1'b0, 1'b1, 5, 64'h1234, 1'b0, 0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 5, 31);
        cyc(1'b0, 1'b1, 31, 64'hFF, 1'b0, 0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 31, 31);
        // Claim X7, stall, release with write of 0xAB.
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 7, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 7, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 7, 0);
        cyc(1'b0, 1'b1, 7, 64'hAB, 1'b0, 0, 1'b1, 7, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 7, 0);
        // Same-cycle claim and write of X9: claim wins.
        cyc(1'b0, 1'b1, 9, 64'h55, 1'b1, 9, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 9, 31);
        cyc(1'b0, 1'b1, 9, 64'h66, 1'b0, 0, 1'b1, 31, 9);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 31, 9);
        // Read X2 while it is being overwritten.
        cyc(1'b0, 1'b1, 2, 64'h10, 1'b0, 0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 2, 64'h20, 1'b0, 0, 1'b1, 2, 31);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 2, 2);
        // Claim X4 then reset: pending cleared, read accepted at once.
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 4, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 4, 4);
        #1;
        check("midreset_valid", 64'(bus.rd_valid), 64'h0);
        check("midreset_data_b", bus.rd_data_b, 64'h0);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, 1'b1, 4, 0);

        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, pick_addr(),
                {$urandom, $urandom}, $urandom_range(0, 3) == 0, pick_addr(),
                $urandom_range(0, 2) != 0, pick_addr(), pick_addr());
        end
        repeat (3) idle();
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
